// File: rtl/tone_voice_allocator.sv
// tone_voice_allocator
//   Shares a pool of NV sine-generator voices among keyboard press/release
//   events. Each accepted event is resolved by a scan over all voices (one
//   voice per cycle), and the result is applied in a single commit cycle.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   ev_valid      event offered
//   ev_ready      allocator can accept an event (IDLE only)
//   ev_press      1 = key press, 0 = key release
//   ev_key        key code
//   ev_freq       phase increment for the key (ignored on release)
//   voice_freq    per-voice freq word, voice i at [i*FW +: FW]
//   voice_active  voice i currently holds a key
//   voice_key     key code held by each voice, voice i at [i*KW +: KW]
//   steal_pulse   one-cycle pulse when an active voice was reassigned
module tone_voice_allocator #(
    parameter int NV = 4,
    parameter int KW = 8,
    parameter int FW = 16,
    parameter int AW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic             ev_press,
    input  logic [KW-1:0]    ev_key,
    input  logic [FW-1:0]    ev_freq,
    output logic [NV*FW-1:0] voice_freq,
    output logic [NV-1:0]    voice_active,
    output logic [NV*KW-1:0] voice_key,
    output logic             steal_pulse
);

    localparam int IW = (NV > 1) ? $clog2(NV) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NV - 1);
    localparam logic [AW-1:0] AGE_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic [IW-1:0]   idx_q, idx_d;

    // Event fields captured at acceptance
    logic            lat_press_q, lat_press_d;
    logic [KW-1:0]   lat_key_q, lat_key_d;
    logic [FW-1:0]   lat_freq_q, lat_freq_d;

    // Scan results
    logic            match_found_q, match_found_d;
    logic [IW-1:0]   match_idx_q, match_idx_d;
    logic            free_found_q, free_found_d;
    logic [IW-1:0]   free_idx_q, free_idx_d;
    logic            old_found_q, old_found_d;
    logic [IW-1:0]   old_idx_q, old_idx_d;
    logic [AW-1:0]   old_age_q, old_age_d;

    // Voice state
    logic [NV-1:0]   active_q, active_d;
    logic [KW-1:0]   vkey_q  [NV];
    logic [KW-1:0]   vkey_d  [NV];
    logic [FW-1:0]   vfreq_q [NV];
    logic [FW-1:0]   vfreq_d [NV];
    logic [AW-1:0]   age_q   [NV];
    logic [AW-1:0]   age_d   [NV];
    logic            steal_q, steal_d;

    function automatic logic [AW-1:0] age_inc(input logic [AW-1:0] a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        lat_press_d   = lat_press_q;
        lat_key_d     = lat_key_q;
        lat_freq_d    = lat_freq_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_found_d   = old_found_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        active_d      = active_q;
        vkey_d        = vkey_q;
        vfreq_d       = vfreq_q;
        age_d         = age_q;
        steal_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (ev_valid && ready_q) begin
                    lat_press_d   = ev_press;
                    lat_key_d     = ev_key;
                    lat_freq_d    = ev_freq;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    old_found_d   = 1'b0;
                    old_age_d     = '0;
                    idx_d         = '0;
                    state_d       = SCAN;
                end
            end

            SCAN: begin
                if (!match_found_q && active_q[idx_q] && (vkey_q[idx_q] == lat_key_q)) begin
                    match_found_d = 1'b1;
                    match_idx_d   = idx_q;
                end
                if (!free_found_q && !active_q[idx_q]) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                // Strict '>' keeps the lowest index on equal ages
                if (active_q[idx_q] && (!old_found_q || (age_q[idx_q] > old_age_q))) begin
                    old_found_d = 1'b1;
                    old_idx_d   = idx_q;
                    old_age_d   = age_q[idx_q];
                end
                if (idx_q == LAST_IDX) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            COMMIT: begin
                state_d = IDLE;
                if (lat_press_q) begin
                    if (match_found_q) begin
                        vfreq_d[match_idx_q] = lat_freq_q;
                    end else if (free_found_q) begin
                        for (int i = 0; i < NV; i++) begin
                            if (active_q[i]) begin
                                age_d[i] = age_inc(age_q[i]);
                            end
                        end
                        active_d[free_idx_q] = 1'b1;
                        vkey_d[free_idx_q]   = lat_key_q;
                        vfreq_d[free_idx_q]  = lat_freq_q;
                        age_d[free_idx_q]    = '0;
                    end else if (old_found_q) begin
                        // Pool is full: every voice is active here
                        for (int i = 0; i < NV; i++) begin
                            if (active_q[i] && (IW'(i) != old_idx_q)) begin
                                age_d[i] = age_inc(age_q[i]);
                            end
                        end
                        vkey_d[old_idx_q]  = lat_key_q;
                        vfreq_d[old_idx_q] = lat_freq_q;
                        age_d[old_idx_q]   = '0;
                        steal_d            = 1'b1;
                    end
                end else if (match_found_q) begin
                    active_d[match_idx_q] = 1'b0;
                    vkey_d[match_idx_q]   = '0;
                    vfreq_d[match_idx_q]  = '0;
                    age_d[match_idx_q]    = '0;
                end
            end

            default: state_d = IDLE;
        endcase

        // Ready is registered so it is high exactly while the FSM sits in IDLE
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            idx_q         <= '0;
            lat_press_q   <= 1'b0;
            lat_key_q     <= '0;
            lat_freq_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_found_q   <= 1'b0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            active_q      <= '0;
            steal_q       <= 1'b0;
            for (int i = 0; i < NV; i++) begin
                vkey_q[i]  <= '0;
                vfreq_q[i] <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            idx_q         <= idx_d;
            lat_press_q   <= lat_press_d;
            lat_key_q     <= lat_key_d;
            lat_freq_q    <= lat_freq_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_found_q   <= old_found_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            active_q      <= active_d;
            steal_q       <= steal_d;
            vkey_q        <= vkey_d;
            vfreq_q       <= vfreq_d;
            age_q         <= age_d;
        end
    end

    always_comb begin
        voice_freq = '0;
        voice_key  = '0;
        for (int i = 0; i < NV; i++) begin
            // Inactive voices are forced silent regardless of stored word
            voice_freq[i*FW +: FW] = active_q[i] ? vfreq_q[i] : '0;
            voice_key[i*KW +: KW]  = vkey_q[i];
        end
    end

    assign voice_active = active_q;
    assign ev_ready     = ready_q;
    assign steal_pulse  = steal_q;

endmodule

// File: tb/tb_tone_voice_allocator.sv
module tb_tone_voice_allocator;

    localparam int NV = 4;
    localparam int KW = 8;
    localparam int FW = 16;
    localparam int AW = 8;

    logic             clk;
    logic             reset;
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_press;
    logic [KW-1:0]    ev_key;
    logic [FW-1:0]    ev_freq;
    logic [NV*FW-1:0] voice_freq;
    logic [NV-1:0]    voice_active;
    logic [NV*KW-1:0] voice_key;
    logic             steal_pulse;

    tone_voice_allocator #(.NV(NV), .KW(KW), .FW(FW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_press     (ev_press),
        .ev_key       (ev_key),
        .ev_freq      (ev_freq),
        .voice_freq   (voice_freq),
        .voice_active (voice_active),
        .voice_key    (voice_key),
        .steal_pulse  (steal_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NV*FW-1:0] freq;
        logic [NV-1:0]    act;
        logic [NV*KW-1:0] key;
        logic             steal;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference voice pool
    bit          m_act  [NV];
    logic [7:0]  m_key  [NV];
    logic [15:0] m_freq [NV];
    int          m_age  [NV];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t pack_model(input bit st);
        exp_t e;
        e.freq = '0;
        e.act  = '0;
        e.key  = '0;
        for (int i = 0; i < NV; i++) begin
            e.act[i]          = m_act[i];
            e.freq[i*FW +: FW] = m_act[i] ? m_freq[i] : 16'h0;
            e.key[i*KW +: KW]  = m_act[i] ? m_key[i] : 8'h0;
        end
        e.steal = st;
        return e;
    endfunction

    task automatic model_apply(input bit p, input logic [7:0] k, input logic [15:0] f, output bit st);
        int hit, fr, old;
        hit = -1; fr = -1; old = -1;
        st  = 1'b0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (m_act[i] && m_key[i] == k) hit = i;
            if (!m_act[i]) fr = i;
        end
        for (int i = 0; i < NV; i++) begin
            if (m_act[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
        end
        if (p) begin
            if (hit >= 0) begin
                m_freq[hit] = f;
            end else begin
                int tgt;
                tgt = (fr >= 0) ? fr : old;
                st  = (fr < 0);
                for (int i = 0; i < NV; i++)
                    if (m_act[i] && i != tgt && m_age[i] < 255) m_age[i]++;
                m_act[tgt]  = 1'b1;
                m_key[tgt]  = k;
                m_freq[tgt] = f;
                m_age[tgt]  = 0;
            end
        end else if (hit >= 0) begin
            m_act[hit]  = 1'b0;
            m_key[hit]  = 8'h0;
            m_freq[hit] = 16'h0;
            m_age[hit]  = 0;
        end
    endtask

    task automatic send(input bit p, input logic [7:0] k, input logic [15:0] f, input bit hold);
        exp_t pre, e;
        bit   st;
        int   w;
        pre = pack_model(1'b0);
        w = 0;
        while (!ev_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!ev_ready) begin
            chk("ready_wait", 64'(ev_ready), 64'd1);
            return;
        end
        ev_valid = 1'b1;
        ev_press = p;
        ev_key   = k;
        ev_freq  = f;
        @(posedge clk); #1;
        model_apply(p, k, f, st);
        sb.push_back(pack_model(st));
        if (!hold) ev_valid = 1'b0;
        for (int c = 1; c <= NV + 1; c++) begin
            if (hold) begin
                ev_press = 1'($urandom_range(0, 1));
                ev_key   = 8'($urandom);
                ev_freq  = 16'($urandom);
            end
            @(posedge clk); #1;
            if (c <= NV) chk("ready_scan", 64'(ev_ready), 64'd0);
            if (c == NV) begin
                chk("early_freq", 64'(voice_freq), 64'(pre.freq));
                chk("early_act", 64'(voice_active), 64'(pre.act));
                chk("early_steal", 64'(steal_pulse), 64'd0);
            end
        end
        ev_valid = 1'b0;
        e = sb.pop_front();
        chk("freq", 64'(voice_freq), 64'(e.freq));
        chk("active", 64'(voice_active), 64'(e.act));
        chk("key", 64'(voice_key), 64'(e.key));
        chk("steal", 64'(steal_pulse), 64'(e.steal));
        chk("ready_done", 64'(ev_ready), 64'd1);
        @(posedge clk); #1;
        chk("steal_len", 64'(steal_pulse), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NV; i++) begin
            m_act[i] = 1'b0; m_key[i] = 8'h0; m_freq[i] = 16'h0; m_age[i] = 0;
        end
        reset    = 1'b1;
        ev_valid = 1'b0;
        ev_press = 1'b0;
        ev_key   = '0;
        ev_freq  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ev_ready), 64'd0);
        chk("rst_freq", 64'(voice_freq), 64'd0);
        chk("rst_act", 64'(voice_active), 64'd0);
        chk("rst_key", 64'(voice_key), 64'd0);
        chk("rst_steal", 64'(steal_pulse), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(ev_ready), 64'd1);

        // Reset in the middle of a scan abandons the press
        ev_valid = 1'b1; ev_press = 1'b1; ev_key = 8'h77; ev_freq = 16'h1234;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_ready", 64'(ev_ready), 64'd0);
        chk("midrst_act", 64'(voice_active), 64'd0);
        chk("midrst_freq", 64'(voice_freq), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_ready_hold", 64'(ev_ready), 64'd0);
        @(posedge clk); #1;
        chk("midrst_ready_up", 64'(ev_ready), 64'd1);
        repeat (NV + 2) @(posedge clk);
        #1;
        chk("midrst_no_alloc", 64'(voice_active), 64'd0);
        chk("midrst_no_key", 64'(voice_key), 64'd0);

        // Fill the pool
        for (int i = 0; i < NV; i++)
            send(1'b1, 8'(8'h10 + i), 16'(16'h0100 * (i + 1)), 1'b0);
        chk("fill_freq", 64'(voice_freq), 64'h0400_0300_0200_0100);

        // Steal the oldest voice
        send(1'b1, 8'h20, 16'h0800, 1'b0);
        chk("steal_v0", 64'(voice_key), 64'h0000_0000_1312_1120);

        // Retrigger a held key
        send(1'b1, 8'h12, 16'h0333, 1'b0);
        chk("retrig_freq", 64'(voice_freq), 64'h0400_0333_0200_0800);

        // Release and reuse
        send(1'b0, 8'h11, 16'hFFFF, 1'b0);
        chk("rel_act", 64'(voice_active), 64'hD);
        send(1'b0, 8'h55, 16'h0000, 1'b0);
        send(1'b1, 8'h30, 16'h0050, 1'b0);
        chk("reuse_v1", 64'(voice_freq), 64'h0400_0333_0050_0800);

        // Held valid with changing fields: first event applied, steals voice 2
        send(1'b1, 8'h40, 16'h0777, 1'b1);
        chk("hold_key", 64'(voice_key), 64'h0000_0000_1340_3020);

        // Zero-frequency press is still an allocation
        send(1'b0, 8'h13, 16'h0000, 1'b0);
        send(1'b1, 8'h50, 16'h0000, 1'b0);
        chk("zero_freq_act", 64'(voice_active), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
